// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, unit selects, MIX float layout and sequencer states shared by the FPU sequencer
package fpu_pkg;
    localparam logic [2:0] FOP_ADD = 3'd1;
    localparam logic [2:0] FOP_SUB = 3'd2;
    localparam logic [2:0] FOP_MUL = 3'd3;
    localparam logic [2:0] FOP_DIV = 3'd4;
    typedef enum logic [1:0] {U_ADD, U_MUL, U_DIV} unit_t;
    typedef struct packed {
        logic        sign;
        logic [5:0]  exp;
        logic [23:0] mant;
    } mix_float_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    function automatic mix_float_t negate(input mix_float_t f);
        return {~f.sign, f.exp, f.mant};
    endfunction
endpackage

// File: rtl/fpu_watchdog.sv
// fpu_watchdog: start-to-stop cycle counter with timeout compare and captured count
//   clr restarts the count, en advances it, cap latches count+1 into cycles, zero clears cycles
//   expired is high when the next count equals TIMEOUT
module fpu_watchdog #(
    parameter int TIMEOUT = 63,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          cap,
    input  logic          zero,
    output logic          expired,
    output logic [CW-1:0] cycles
);
    logic [CW-1:0] cnt, nxt;
    assign nxt     = cnt + CW'(1);
    assign expired = nxt == CW'(TIMEOUT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt    <= '0;
            cycles <= '0;
        end else begin
            cnt    <= clr ? '0 : en ? nxt : cnt;
            cycles <= zero ? '0 : cap ? nxt : cycles;
        end
endmodule

// File: rtl/fpu_seq.sv
// fpu_seq: issues one MIX floating command to fadd/fmul/fdiv and returns its result with a done pulse
//   req/op/opa/opb: command from the CPU; u_in1/u_in2 and *_start: operand buses and unit starts
//   *_out/*_stop/*_ovf: unit answers; busy/done/result/ovf/err/cycles: status back to the CPU
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = 63,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [2:0]    op,
    input  logic [30:0]   opa,
    input  logic [30:0]   opb,
    output logic [30:0]   u_in1,
    output logic [30:0]   u_in2,
    output logic          add_start,
    output logic          mul_start,
    output logic          div_start,
    input  logic [30:0]   add_out,
    input  logic [30:0]   mul_out,
    input  logic [30:0]   div_out,
    input  logic          add_stop,
    input  logic          mul_stop,
    input  logic          div_stop,
    input  logic          add_ovf,
    input  logic          mul_ovf,
    input  logic          div_ovf,
    output logic          busy,
    output logic          done,
    output logic [30:0]   result,
    output logic          ovf,
    output logic          err,
    output logic [CW-1:0] cycles
);
    state_t      state;
    unit_t       unit, sel;
    mix_float_t  a, b;
    logic        legal, stop_sel, ovf_sel, expired, cap;
    logic [30:0] out_sel;
    assign legal    = op inside {FOP_ADD, FOP_SUB, FOP_MUL, FOP_DIV};
    assign sel      = op == FOP_MUL ? U_MUL : op == FOP_DIV ? U_DIV : U_ADD;
    assign stop_sel = unit == U_MUL ? mul_stop : unit == U_DIV ? div_stop : add_stop;
    assign ovf_sel  = unit == U_MUL ? mul_ovf : unit == U_DIV ? div_ovf : add_ovf;
    assign out_sel  = unit == U_MUL ? mul_out : unit == U_DIV ? div_out : add_out;
    // a stop in the same cycle as the timeout still counts as an answer
    assign cap      = state == S_WAIT && (stop_sel || expired);
    assign u_in1    = a;
    assign u_in2    = b;
    fpu_watchdog #(.TIMEOUT(TIMEOUT), .CW(CW)) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == S_ISSUE),
        .en      (state == S_WAIT),
        .cap     (cap),
        .zero    (state == S_IDLE && req && !legal),
        .expired (expired),
        .cycles  (cycles)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= S_IDLE;
            unit      <= U_ADD;
            a         <= '0;
            b         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            add_start <= 1'b0;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            done      <= 1'b0;
            add_start <= 1'b0;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            case (state)
                S_IDLE: if (req) begin
                    busy <= 1'b1;
                    ovf  <= 1'b0;
                    if (legal) begin
                        a         <= opa;
                        b         <= op == FOP_SUB ? negate(opb) : opb;
                        unit      <= sel;
                        err       <= 1'b0;
                        add_start <= sel == U_ADD;
                        mul_start <= sel == U_MUL;
                        div_start <= sel == U_DIV;
                        state     <= S_ISSUE;
                    end else begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: if (cap) begin
                    result <= stop_sel ? out_sel : '0;
                    ovf    <= stop_sel & ovf_sel;
                    err    <= ~stop_sel;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: directed stimulus with stub units, a transaction-level timeline model and literal checks
module tb_fpu_seq;
    import fpu_pkg::*;
    localparam int TO = 63;
    localparam int CW = 8;
    localparam logic [30:0] P_A    = {1'b0, 6'o41, 24'h400000};
    localparam logic [30:0] P_B    = {1'b0, 6'o40, 24'h200000};
    localparam logic [30:0] P_MULR = {1'b0, 6'o42, 24'h100000};
    logic clk = 0, rst_n = 0, req = 0, req1 = 0;
    logic [2:0] op = 0;
    logic [30:0] opa = 0, opb = 0;
    logic [30:0] u_in1, u_in2, add_out, mul_out, div_out, result;
    logic add_start, mul_start, div_start, add_stop, mul_stop, div_stop, add_ovf, mul_ovf, div_ovf;
    logic busy, done, ovf, err;
    logic [CW-1:0] cycles;
    logic [30:0] t_in1, t_in2, t_result;
    logic t_add_start, t_mul_start, t_div_start, t_busy, t_done, t_ovf, t_err;
    logic t_div_stop = 0;
    logic [CW-1:0] t_cycles;
    int lat[3];
    logic [30:0] val[3];
    logic ov[3];
    logic mstop[3];
    int rem[3] = '{0, 0, 0};
    logic sstop[3] = '{0, 0, 0};
    logic [2:0] starts_v;
    int cyc = 0, n_cmp = 0, n_bad = 0;
    int m_acc = -10, m_done = -10, m_u = -1, m_n = 0;
    bit m_bz, m_to;
    logic [30:0] m_a = 0, m_b = 0, f_res = 0, e_res = 0;
    logic f_ovf = 0, e_ovf = 0, f_err = 0, e_err = 0;
    logic [CW-1:0] f_cyc = 0, e_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_seq #(.TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .opa(opa), .opb(opb),
        .u_in1(u_in1), .u_in2(u_in2),
        .add_start(add_start), .mul_start(mul_start), .div_start(div_start),
        .add_out(add_out), .mul_out(mul_out), .div_out(div_out),
        .add_stop(add_stop), .mul_stop(mul_stop), .div_stop(div_stop),
        .add_ovf(add_ovf), .mul_ovf(mul_ovf), .div_ovf(div_ovf),
        .busy(busy), .done(done), .result(result), .ovf(ovf), .err(err), .cycles(cycles)
    );

    fpu_seq #(.TIMEOUT(5), .CW(CW)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req1), .op(op), .opa(opa), .opb(opb),
        .u_in1(t_in1), .u_in2(t_in2),
        .add_start(t_add_start), .mul_start(t_mul_start), .div_start(t_div_start),
        .add_out(add_out), .mul_out(mul_out), .div_out(div_out),
        .add_stop(1'b0), .mul_stop(1'b0), .div_stop(t_div_stop),
        .add_ovf(1'b0), .mul_ovf(1'b0), .div_ovf(1'b0),
        .busy(t_busy), .done(t_done), .result(t_result), .ovf(t_ovf), .err(t_err), .cycles(t_cycles)
    );

    // stub units: stop pulses lat cycles after start (lat=0 never answers), plus manual pulses
    assign starts_v = {div_start, mul_start, add_start};
    assign add_stop = sstop[0] | mstop[0];
    assign mul_stop = sstop[1] | mstop[1];
    assign div_stop = sstop[2] | mstop[2];
    assign add_out  = val[0];
    assign mul_out  = val[1];
    assign div_out  = val[2];
    assign add_ovf  = ov[0];
    assign mul_ovf  = ov[1];
    assign div_ovf  = ov[2];
    always @(posedge clk)
        for (int u = 0; u < 3; u++) begin
            sstop[u] <= 1'b0;
            if (starts_v[u]) begin
                rem[u]   <= lat[u] > 1 ? lat[u] - 1 : 0;
                sstop[u] <= lat[u] == 1;
            end else if (rem[u] > 0) begin
                rem[u]   <= rem[u] - 1;
                sstop[u] <= rem[u] == 1;
            end
        end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [30:0] x, input logic [30:0] y, output int c0);
        op = o; opa = x; opb = y; req = 1; c0 = cyc;
        tick();
        req = 0;
    endtask

    task automatic wait_done(input int lim, output int dc);
        dc = -1;
        for (int i = 0; i < lim && dc < 0; i++)
            if (done) dc = cyc;
            else tick();
        chk("done_seen", dc >= 0, 1);
    endtask

    // timeline model: a command accepted at cycle c answered N cycles after start finishes at c+N+2
    always @(negedge clk) begin
        if (!rst_n) begin
            m_acc = -10; m_done = -10; m_u = -1; m_a = 0; m_b = 0;
            {e_res, e_ovf, e_err, e_cyc} = '0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_starts", starts_v, 0);
            chk("rst_outs", {result, ovf, err, cycles}, 0);
        end else begin
            m_bz = cyc > m_acc && cyc <= m_done;
            if (m_u >= 0 && cyc == m_acc + 1) {e_ovf, e_err} = 2'b00;
            if (cyc == m_done) {e_res, e_ovf, e_err, e_cyc} = {f_res, f_ovf, f_err, f_cyc};
            chk("busy", busy, m_bz);
            chk("done", done, cyc == m_done);
            chk("starts", starts_v, (m_u >= 0 && cyc == m_acc + 1) ? (3'b001 << m_u) : 3'b000);
            chk("result", result, e_res);
            chk("ovf", ovf, e_ovf);
            chk("err", err, e_err);
            chk("cycles", cycles, e_cyc);
            if (m_bz && m_u >= 0) begin
                chk("u_in1", u_in1, m_a);
                chk("u_in2", u_in2, m_b);
            end
            if (req && !m_bz) begin
                m_acc = cyc;
                m_u = op == FOP_MUL ? 1 : op == FOP_DIV ? 2 : (op == FOP_ADD || op == FOP_SUB) ? 0 : -1;
                if (m_u < 0) begin
                    m_done = cyc + 1;
                    {f_res, f_ovf, f_err, f_cyc} = {31'b0, 1'b0, 1'b1, 8'b0};
                end else begin
                    m_to   = lat[m_u] < 1 || lat[m_u] > TO;
                    m_n    = m_to ? TO : lat[m_u];
                    m_done = cyc + m_n + 2;
                    f_res  = m_to ? 31'b0 : val[m_u];
                    f_ovf  = m_to ? 1'b0 : ov[m_u];
                    f_err  = m_to;
                    f_cyc  = CW'(m_n);
                    m_a    = opa;
                    m_b    = op == FOP_SUB ? opb ^ 31'h40000000 : opb;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_guard: simulation stalled at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0, dc, dc2, cnt;
        for (int u = 0; u < 3; u++) begin
            lat[u] = 0; val[u] = 0; ov[u] = 0; mstop[u] = 0;
        end
        repeat (3) tick();
        chk("lit_rst_busy", {busy, done, t_busy, t_done}, 0);
        chk("lit_rst_outs", {result, cycles, err}, 0);
        rst_n = 1;
        tick();
        // FMUL with a 7-cycle multiplier
        lat[1] = 7; val[1] = P_MULR;
        issue(FOP_MUL, P_A, P_A, c0);
        chk("lit_fmul_start", starts_v, 3'b010);
        tick();
        chk("lit_fmul_start_once", mul_start, 0);
        wait_done(20, dc);
        chk("lit_fmul_lat", dc - c0, 9);
        chk("lit_fmul_res", result, P_MULR);
        chk("lit_fmul_flags", {ovf, err}, 0);
        chk("lit_fmul_cycles", cycles, 7);
        tick();
        // FSUB inverts operand 2 sign
        lat[0] = 3; val[0] = 31'h1234567;
        issue(FOP_SUB, P_A, P_A, c0);
        chk("lit_fsub_start", starts_v, 3'b001);
        chk("lit_fsub_inv", u_in2[30], 1);
        chk("lit_fsub_in1", u_in1, P_A);
        wait_done(20, dc);
        chk("lit_fsub_lat", dc - c0, 5);
        chk("lit_fsub_res", result, 31'h1234567);
        chk("lit_fsub_cycles", cycles, 3);
        chk("lit_fsub_in2_done", u_in2, {1'b1, 6'o41, 24'h400000});
        tick();
        // illegal op
        issue(3'd7, P_A, P_B, c0);
        chk("lit_ill_done", done, 1);
        chk("lit_ill_outs", {err, ovf, result, cycles}, {1'b1, 1'b0, 31'b0, 8'b0});
        chk("lit_ill_starts", starts_v, 0);
        tick();
        // FDIV answering on the first WAIT cycle, with overflow
        lat[2] = 1; val[2] = 31'h7fffffff; ov[2] = 1;
        issue(FOP_DIV, P_A, P_B, c0);
        wait_done(10, dc);
        chk("lit_fdiv_lat", dc - c0, 3);
        chk("lit_fdiv_flags", {ovf, err, cycles}, {1'b1, 1'b0, 8'd1});
        tick();
        // stop on the very cycle the timeout would fire: stop wins
        lat[2] = TO; val[2] = 31'h0055aa; ov[2] = 0;
        issue(FOP_DIV, P_B, P_A, c0);
        wait_done(100, dc);
        chk("lit_edge_lat", dc - c0, TO + 2);
        chk("lit_edge_outs", {err, result, cycles}, {1'b0, 31'h0055aa, 8'(TO)});
        tick();
        // divider never answers
        lat[2] = 0;
        issue(FOP_DIV, P_A, P_A, c0);
        wait_done(100, dc);
        chk("lit_to_lat", dc - c0, TO + 2);
        chk("lit_to_outs", {err, result, cycles}, {1'b1, 31'b0, 8'(TO)});
        tick();
        mstop[2] = 1;
        tick();
        mstop[2] = 0;
        chk("lit_late_stop", {busy, done}, 0);
        // TIMEOUT=5 instance
        op = FOP_DIV; req1 = 1; c0 = cyc;
        tick();
        req1 = 0;
        dc = -1;
        for (int i = 0; i < 20 && dc < 0; i++)
            if (t_done) dc = cyc;
            else tick();
        chk("lit_to5_lat", dc - c0, 7);
        chk("lit_to5_outs", {t_err, t_ovf, t_result, t_cycles}, {1'b1, 1'b0, 31'b0, 8'd5});
        tick();
        tick();
        t_div_stop = 1;
        tick();
        t_div_stop = 0;
        cnt = 0;
        repeat (4) begin
            cnt += t_busy | t_done;
            tick();
        end
        chk("lit_to5_late_stop", cnt, 0);
        // requests while busy are dropped; a held FADD is taken right after DONE
        lat[1] = 7; val[1] = 31'h0ABCDEF; lat[0] = 2; val[0] = 31'h0123456;
        issue(FOP_MUL, P_A, P_B, c0);
        tick();
        tick();
        op = FOP_MUL; req = 1; mstop[0] = 1; mstop[2] = 1;
        tick();
        req = 0; mstop[0] = 0; mstop[2] = 0;
        op = FOP_ADD; opa = P_B; opb = P_A; req = 1;
        dc = -1;
        for (int i = 0; i < 20 && dc < 0; i++)
            if (done) dc = cyc;
            else tick();
        chk("lit_busy_lat", dc - c0, 9);
        chk("lit_busy_res", result, 31'h0ABCDEF);
        tick();
        chk("lit_held_idle", busy, 0);
        tick();
        chk("lit_held_start", starts_v, 3'b001);
        req = 0;
        wait_done(10, dc2);
        chk("lit_held_lat", dc2 - (dc + 1), 4);
        chk("lit_held_res", result, 31'h0123456);
        tick();
        // reset in the middle of WAIT
        lat[1] = 7;
        issue(FOP_MUL, P_A, P_A, c0);
        repeat (3) tick();
        rst_n = 0;
        #1;
        chk("lit_midrst", {busy, done, starts_v, result, cycles}, 0);
        tick();
        rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (cyc == c0 + 8) chk("lit_midrst_stub_stop", mul_stop, 1);
            cnt += done | busy;
            tick();
        end
        chk("lit_midrst_no_done", cnt, 0);
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fpu_seq.md
Name: fpu_seq

Overview:
- Sequencer between the MIX CPU core and the floating-point units: fadd (shared by FADD and FSUB), fmul and fdiv.
- Accepts one floating command at a time, latches both 31-bit operands and pulses the selected unit's start.
- Waits for that unit's stop, then captures the result and overflow and returns them to the CPU with a one-cycle done pulse.
- A watchdog aborts a unit that never answers.

Parameters:
- TIMEOUT, 63, max cycles from unit start to stop before abort (1..255)
- CW, 8, width of the cycle counter / cycles output

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  command request, sampled only when busy=0
- op  in  3  1=FADD 2=FSUB 3=FMUL 4=FDIV, others illegal
- opa  in  31  first operand (rA), MIX float {sign,exp[5:0],mant[23:0]}
- opb  in  31  second operand (memory V)
- u_in1  out  31  operand 1 bus to all units
- u_in2  out  31  operand 2 bus to all units
- add_start, mul_start, div_start  out  1 each  unit start pulses
- add_out, mul_out, div_out  in  31 each  unit results
- add_stop, mul_stop, div_stop  in  1 each  unit completion pulses
- add_ovf, mul_ovf, div_ovf  in  1 each  unit overflow, valid with stop
- busy  out  1  command in flight
- done  out  1  one-cycle completion pulse
- result  out  31  result, held until next accepted req
- ovf  out  1  overflow of last command, held
- err  out  1  illegal op or timeout of last command, held
- cycles  out  CW  start-to-stop count of last command, held

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, all starts, result, ovf, err, cycles and the operand registers are 0.
  - Reset mid-command abandons it. A stop arriving later in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req=1 with a legal op: latch opa into A and opb into B.
  - For FSUB, B latches with bit30 inverted.
  - Latch unit select (add for ops 1/2, mul for 3, div for 4), clear ovf/err, go to ISSUE.
  - req=1 with an illegal op: result=0, err=1, ovf=0, cycles=0, go to DONE without touching any unit.
- ISSUE (one cycle):
  - The selected unit's start=1; the other starts stay 0. Counter=0.
  - Go to WAIT.
- u_in1=A and u_in2=B drive continuously from the registers from ISSUE through DONE, so operand 2 is stable on the cycle after start. The multiplier samples operand 2 there.
- WAIT:
  - Counter increments every cycle.
  - Selected stop=1: capture the unit's out into result, its ovf into ovf, counter+1 into cycles, go to DONE.
  - Stops from non-selected units are ignored.
  - Counter reaching TIMEOUT with no stop: result=0, err=1, cycles=TIMEOUT, go to DONE.
  - If stop and timeout occur in the same cycle, stop wins.
- DONE (one cycle): done=1, then IDLE.
- busy=1 in ISSUE, WAIT and DONE.
- req while busy is dropped: no queue, no acknowledgement. The CPU holds req until it sees busy=1 or done.
- A new req is accepted in the cycle after DONE at the earliest. Back-to-back throughput is therefore 1 cycle of idle between commands.
- Latency: req accepted at cycle 0, start at cycle 1. A unit with stop N cycles after start gives done at cycle N+2 and cycles=N. For fmul, N=7: done at cycle 9, cycles=7.
- Outputs result, ovf, err and cycles are registered and stable from done until the next accepted req.

Decomposition:
- Shared package fpu_pkg:
  - op encodings FOP_ADD=1, FOP_SUB=2, FOP_MUL=3, FOP_DIV=4
  - unit-select constants
  - float field positions: SIGN=30, EXP=29:24, MANT=23:0
  - state encoding
- One natural sub-module, fpu_watchdog: counter with clear, enable, TIMEOUT compare and captured count.
- Everything else stays flat in fpu_seq.

Test Plan:
- FMUL, opa=0_41_400000, opb=0_41_400000 (octal exponent, hex mantissa), with the real fmul attached:
  - mul_start at cycle 1 only.
  - done at cycle 9, result=0_42_100000, ovf=0, err=0, cycles=7.
- FSUB, opa=0_41_400000, opb=0_41_400000, add unit stub:
  - u_in2 bit30=1 during ISSUE..DONE.
  - add_start pulses; mul_start and div_start stay 0.
  - Stub stop after 3 cycles: done at cycle 5, result=stub value.
- Illegal op=7 with req=1:
  - No start pulse.
  - done at cycle 1, err=1, result=0, cycles=0.
- Timeout with TIMEOUT=5, div stub never stops:
  - done at cycle 7, err=1, result=0, cycles=5.
  - A div_stop arriving after that in IDLE leaves busy=0 and no done.
- Busy behaviour: req with op=3 while in WAIT of an FMUL is ignored, and exactly one done occurs. An FADD req held through done is then accepted the cycle after DONE.
- Reset mid-WAIT: rst_n=0 at cycle 4 of an FMUL immediately clears busy and the starts; no done follows. mul_stop at cycle 8 is ignored.
